mux_nto1_hs: RTL and testbench
==============================

Name: mux_nto1_hs

Overview:
- Parametrised successor to the team's 4-bit 2:1 mux: NCH-input, WIDTH-bit multiplexer with a registered output.
- Per-channel valid/ready handshake on the inputs and a single valid/ready handshake on the output.
- Two select modes: explicit select (mode 0) or round-robin arbitration (mode 1).
- Sits between multiple producer blocks and one shared consumer; replaces combinational mux_21 instances where flow control and registering are needed.

Parameters:
- WIDTH, 4, data width per channel (>=1).
- NCH, 4, number of input channels (2..16).
- SELW, $clog2(NCH) as localparam (min 1), width of the select/channel-id fields.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-low.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel data valid.
- in_ready  output  NCH  per-channel accept; at most one bit high per cycle.
- mode  input  1  0 = explicit select, 1 = round-robin.
- sel  input  SELW  channel select, used in mode 0 only.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data/out_ch hold an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- out_ch  output  SELW  index of the channel that supplied out_data.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_ch=0, rr_ptr=NCH-1 (channel 0 has first priority).
- All state leaves reset on the first clk edge after rst_n rises.

Load and handshake:
- load_en = !out_valid || out_ready.
- in_ready[i] = load_en && (i == grant) && grant_vld. This is combinational from in_valid, mode, sel, rr_ptr and out_ready.
- A transfer occurs on a channel when in_valid[i] && in_ready[i].
- On a transfer: out_data <= channel data, out_ch <= i, out_valid <= 1 on the next edge. Latency is 1 cycle.
- When out_valid && out_ready with no new transfer: out_valid <= 0; out_data and out_ch hold their last values.
- Simultaneous consume and load in one cycle: the new word replaces the old one with no bubble, sustaining 1 word/cycle.
- When out_valid && !out_ready: out_data, out_ch and out_valid hold, and all in_ready are 0.

Mode 0 (explicit select):
- grant = sel; grant_vld = in_valid[sel] && (sel < NCH).
- sel >= NCH: no grant, all in_ready are 0, nothing is loaded.
- rr_ptr is unchanged in mode 0.

Mode 1 (round-robin):
- Search channels rr_ptr+1, rr_ptr+2, ... modulo NCH; grant the first with in_valid high.
- grant_vld = |in_valid.
- rr_ptr <= grant only on a transfer, so a stalled output does not advance priority.
- Wrap-around: after channel NCH-1 the search continues at channel 0.
- A single requesting channel is granted every cycle that load_en is high.

Mode changes and input rules:
- mode and sel are sampled combinationally each cycle.
- A change affects only the next grant; a word already held in the output register is unaffected.
- Inputs must keep in_data/in_valid stable until accepted; the block does not check this.
- Reset asserted mid-transfer discards the held word immediately (out_valid drops asynchronously).

Optional Feature:
- Macro: MUX_PARITY_EN.
- Defined: adds output port out_parity (1 bit), registered alongside out_data as the XOR-reduction of the loaded data. It resets to 0, holds with out_data, and has the same 1-cycle latency.
- Undefined: port absent, no parity logic; all other behaviour is identical.

Test Plan (WIDTH=4, NCH=4):
- Mode 0 basic: ch0=4'b1010, ch1=4'b0101, all valid, out_ready=1; sel=0 then sel=1 -> out_data 1010 (out_ch 0) then 0101 (out_ch 1), each 1 cycle after the sel change; in_ready=0001 then 0010.
- Backpressure: mode 0, sel=2, ch2=4'b1111 valid, out_ready=0 for 3 cycles -> out_valid=1, out_data=1111 held, in_ready=0000 during the stall; out_ready=1 -> next word loads the same cycle (no bubble).
- Round-robin fairness: mode 1, all four valid (1111, 0000, 0011, 1100), out_ready=1 from reset -> out_ch sequence 0,1,2,3,0 on consecutive cycles; data matches each channel.
- Round-robin sparse/wrap: mode 1, only ch3 and ch1 valid, rr_ptr=3 -> grants 1,3,1,3; ch3 dropped after its grant -> grants continue 1,1,1.
- Boundary and reset: mode 0, sel=3 with in_valid[3]=0 -> no load, out_valid falls after consume. Assert rst_n low mid-stream with out_valid=1 -> out_valid=0, out_data=0 immediately, first post-reset RR grant is ch0.
- MUX_PARITY_EN defined: load 4'b1011 -> out_parity=1; load 4'b0011 -> out_parity=0, both aligned with out_data.

Source files
------------

// File: rtl/mux_nto1_hs.sv
// mux_nto1_hs: NCH-input, WIDTH-bit multiplexer with a registered output.
// It has a valid/ready handshake on each input and on the output, and two
// select modes: explicit select or round-robin.
// Optional feature: define MUX_PARITY_EN to add the out_parity output.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    NCH*WIDTH packed channel data; channel i is at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel accept; at most one bit is high
//   mode       0 = explicit select, 1 = round-robin
//   sel        channel select, used only in mode 0
//   out_data   registered selected word
//   out_valid  out_data/out_ch hold an unconsumed word
//   out_ready  the consumer accepts the word
//   out_ch     index of the channel that supplied out_data
//   out_parity (MUX_PARITY_EN only) XOR-reduction of out_data
module mux_nto1_hs #(
    parameter int WIDTH = 4,
    parameter int NCH = 4,
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef MUX_PARITY_EN
    output logic                 out_parity,
`endif
    output logic [SELW-1:0]      out_ch
);
    logic [SELW-1:0]  rr_ptr;
    logic [SELW-1:0]  rr_grant;
    logic [SELW-1:0]  grant;
    logic             grant_vld;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] grant_data;

    // Round-robin search: the offsets are scanned from the farthest to the
    // nearest, so the closest valid channel after rr_ptr is the last one
    // written.
    always_comb begin
        rr_grant = '0;
        for (int k = NCH; k >= 1; k--) begin
            if (in_valid[(int'(rr_ptr) + k) % NCH])
                rr_grant = SELW'((int'(rr_ptr) + k) % NCH);
        end
    end

    assign grant     = mode ? rr_grant : sel;
    assign grant_vld = mode ? |in_valid : (int'(sel) < NCH) && in_valid[sel];
    assign load_en   = !out_valid || out_ready;
    assign xfer      = load_en && grant_vld;
    assign grant_data = in_data[int'(grant)*WIDTH +: WIDTH];

    always_comb begin
        in_ready = '0;
        if (xfer)
            in_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= SELW'(NCH - 1);
`ifdef MUX_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_ch    <= grant;
`ifdef MUX_PARITY_EN
            out_parity <= ^grant_data;
`endif
            // Priority only moves on an actual transfer in round-robin mode.
            if (mode)
                rr_ptr <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_nto1_hs.sv
// tb_mux_nto1_hs: directed self-checking bench for mux_nto1_hs (WIDTH=4, NCH=4).
module tb_mux_nto1_hs;
    localparam int WIDTH = 4;
    localparam int NCH = 4;
    localparam int SELW = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SELW-1:0]      out_ch;
`ifdef MUX_PARITY_EN
    logic                 out_parity;
`endif

    int n_chk = 0;
    int n_fail = 0;

    mux_nto1_hs #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .mode(mode),
        .sel(sel),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef MUX_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_ch(out_ch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] d, input logic [1:0] c);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_data"}, 32'(out_data), 32'(d));
        chk({tag, "_ch"}, 32'(out_ch), 32'(c));
    endtask

    logic [1:0] rr_exp_ch [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] rr_exp_d  [5] = '{4'b1111, 4'b0000, 4'b0011, 4'b1100, 4'b1111};

    initial begin
        // Reset state
        rst_n = 1'b0;
        in_data = {4'b0110, 4'b1111, 4'b0101, 4'b1010};
        in_valid = 4'b1111;
        mode = 1'b0;
        sel = 2'd0;
        out_ready = 1'b1;
        #2;
        chk_out("reset", 1'b0, 4'b0000, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("m0_rdy_sel0", 32'(in_ready), 32'b0001);

        // Mode 0 basic
        tick();
        chk_out("m0_sel0", 1'b1, 4'b1010, 2'd0);
        sel = 2'd1;
        #1;
        chk("m0_rdy_sel1", 32'(in_ready), 32'b0010);
        tick();
        chk_out("m0_sel1", 1'b1, 4'b0101, 2'd1);

        // Backpressure
        sel = 2'd2;
        tick();
        chk_out("bp_load", 1'b1, 4'b1111, 2'd2);
        out_ready = 1'b0;
        in_data[11:8] = 4'b0001;
        #1;
        chk("bp_rdy0", 32'(in_ready), 32'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("bp_hold", 1'b1, 4'b1111, 2'd2);
            chk("bp_rdy", 32'(in_ready), 32'b0000);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(in_ready), 32'b0100);
        tick();
        chk_out("bp_nobubble", 1'b1, 4'b0001, 2'd2);

        // Select a channel that is not valid: nothing loads, the word drains
        in_valid = 4'b0111;
        sel = 2'd3;
        #1;
        chk("inv_rdy", 32'(in_ready), 32'b0000);
        tick();
        chk_out("inv_drain", 1'b0, 4'b0001, 2'd2);

        // Reset in the middle of a stream
        in_valid = 4'b1111;
        sel = 2'd0;
        tick();
        chk_out("pre_rst", 1'b1, 4'b1010, 2'd0);
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 4'b0000, 2'd0);

        // Round-robin fairness starting from reset
        in_data = {4'b1100, 4'b0011, 4'b0000, 4'b1111};
        mode = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("rr_fair%0d", i), 1'b1, rr_exp_d[i], rr_exp_ch[i]);
        end

        // Round-robin with sparse requests and wrap-around
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rr_sparse%0d", i), 32'(out_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
        end
        in_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("rr_single_rdy%0d", i), 32'(in_ready), 32'b0010);
            tick();
            chk($sformatf("rr_single%0d", i), 32'(out_ch), 32'd1);
        end

        // A stall must not advance round-robin priority
        in_valid = 4'b1010;
        out_ready = 1'b0;
        tick();
        chk_out("rr_stall", 1'b1, 4'b0000, 2'd1);
        out_ready = 1'b1;
        #1;
        chk("rr_stall_rdy", 32'(in_ready), 32'b1000);
        tick();
        chk_out("rr_after_stall", 1'b1, 4'b1100, 2'd3);

`ifdef MUX_PARITY_EN
        mode = 1'b0;
        sel = 2'd0;
        in_valid = 4'b0001;
        in_data[3:0] = 4'b1011;
        tick();
        chk("par_data1", 32'(out_data), 32'b1011);
        chk("par1", 32'(out_parity), 32'd1);
        in_data[3:0] = 4'b0011;
        tick();
        chk("par_data0", 32'(out_data), 32'b0011);
        chk("par0", 32'(out_parity), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
